// File: rtl/cpu_pkg.sv
// Shared sizing for the CPU register file: data width, register counts and
// the address widths derived from them.
package cpu_pkg;

    localparam int CPU_DATA_W    = 32;
    localparam int CPU_NUM_REGS  = 16;
    localparam int CPU_NUM_BREGS = 8;
    localparam int CPU_REG_AW    = $clog2(CPU_NUM_REGS);
    localparam int CPU_BREG_AW   = $clog2(CPU_NUM_BREGS);

endpackage

// File: rtl/cpu_scoreboard.sv
// One pending bit per register: set on issue, cleared on writeback, with issue
// winning when both target the same register on the same edge.
module cpu_scoreboard
    import cpu_pkg::*;
#(
    parameter int N           = CPU_NUM_BREGS,
    parameter int AW          = $clog2(N),
    parameter bit ZERO_LOCKED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    output logic [N-1:0]  pend_live
);

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        // A locked entry 0 (hardwired-zero register) can never become pending.
        if (set_en && !(ZERO_LOCKED && set_addr == '0)) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        pend_d    = (pend_q & ~clr_mask) | set_mask;
        pend_live = pend_q & ~(clr_mask & ~set_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

endmodule

// File: rtl/cpu_regfile.sv
// General and B register files with 1-cycle registered reads, writeback
// bypass, and an issue/writeback scoreboard producing a registered hazard flag.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W    = CPU_DATA_W,
    parameter int NUM_REGS  = CPU_NUM_REGS,
    parameter int NUM_BREGS = CPU_NUM_BREGS,
    parameter int REG_AW    = $clog2(NUM_REGS),
    parameter int BREG_AW   = $clog2(NUM_BREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_wr_reg,
    input  logic [REG_AW-1:0]  wb_rd_addr,
    input  logic [DATA_W-1:0]  wb_rd_data,
    input  logic               wb_wr_breg,
    input  logic [BREG_AW-1:0] wb_bd_addr,
    input  logic [DATA_W-1:0]  wb_bd_data,
    input  logic [REG_AW-1:0]  rs1_addr,
    input  logic [REG_AW-1:0]  rs2_addr,
    input  logic [BREG_AW-1:0] bs_addr,
    output logic [DATA_W-1:0]  rs1_data,
    output logic [DATA_W-1:0]  rs2_data,
    output logic [DATA_W-1:0]  bs_data,
    input  logic               iss_valid,
    input  logic               iss_is_breg,
    input  logic [REG_AW-1:0]  iss_dst_addr,
    output logic               hazard
);

    // Strobes are single-cycle qualifiers: wb_wr_* and iss_valid each act on
    // exactly the rising edge where they are high; there is no backpressure.

    logic [DATA_W-1:0] regs_q  [NUM_REGS];
    logic [DATA_W-1:0] regs_d  [NUM_REGS];
    logic [DATA_W-1:0] bregs_q [NUM_BREGS];
    logic [DATA_W-1:0] bregs_d [NUM_BREGS];
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] bs_data_q,  bs_data_d;
    logic              hazard_q,   hazard_d;
    logic [NUM_REGS-1:0]  gen_live;
    logic [NUM_BREGS-1:0] b_live;

    cpu_scoreboard #(.N(NUM_REGS), .AW(REG_AW), .ZERO_LOCKED(1'b1)) u_gen_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_valid && !iss_is_breg),
        .set_addr  (iss_dst_addr),
        .clr_en    (wb_wr_reg),
        .clr_addr  (wb_rd_addr),
        .pend_live (gen_live)
    );

    cpu_scoreboard #(.N(NUM_BREGS), .AW(BREG_AW), .ZERO_LOCKED(1'b0)) u_b_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_valid && iss_is_breg),
        .set_addr  (iss_dst_addr[BREG_AW-1:0]),
        .clr_en    (wb_wr_breg),
        .clr_addr  (wb_bd_addr),
        .pend_live (b_live)
    );

    always_comb begin
        regs_d  = regs_q;
        bregs_d = bregs_q;
        if (wb_wr_reg && wb_rd_addr != '0) regs_d[wb_rd_addr] = wb_rd_data;
        if (wb_wr_breg) bregs_d[wb_bd_addr] = wb_bd_data;
        // Reading the post-write arrays gives same-edge writeback bypass.
        rs1_data_d = regs_d[rs1_addr];
        rs2_data_d = regs_d[rs2_addr];
        bs_data_d  = bregs_d[bs_addr];
        hazard_d   = gen_live[rs1_addr] | gen_live[rs2_addr] | b_live[bs_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)  regs_q[i]  <= '0;
            for (int i = 0; i < NUM_BREGS; i++) bregs_q[i] <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            bs_data_q  <= '0;
            hazard_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            bregs_q    <= bregs_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            bs_data_q  <= bs_data_d;
            hazard_q   <= hazard_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign bs_data  = bs_data_q;
    assign hazard   = hazard_q;

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed bench for cpu_regfile: the driver queues hand-computed read results,
// a monitor compares them one cycle after the addresses are sampled.
module tb_cpu_regfile;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_wr_reg = 1'b0;
    logic [3:0]    wb_rd_addr = '0;
    logic [W-1:0]  wb_rd_data = '0;
    logic          wb_wr_breg = 1'b0;
    logic [2:0]    wb_bd_addr = '0;
    logic [W-1:0]  wb_bd_data = '0;
    logic [3:0]    rs1_addr = '0;
    logic [3:0]    rs2_addr = '0;
    logic [2:0]    bs_addr = '0;
    logic [W-1:0]  rs1_data, rs2_data, bs_data;
    logic          iss_valid = 1'b0;
    logic          iss_is_breg = 1'b0;
    logic [3:0]    iss_dst_addr = '0;
    logic          hazard;

    logic          rd_req = 1'b0;
    logic          rd_vld = 1'b0;
    logic [3*W:0]  exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    // clock / reset
    always #5 clk = ~clk;

    cpu_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .wb_wr_reg    (wb_wr_reg),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_data   (wb_rd_data),
        .wb_wr_breg   (wb_wr_breg),
        .wb_bd_addr   (wb_bd_addr),
        .wb_bd_data   (wb_bd_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .bs_addr      (bs_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .bs_data      (bs_data),
        .iss_valid    (iss_valid),
        .iss_is_breg  (iss_is_breg),
        .iss_dst_addr (iss_dst_addr),
        .hazard       (hazard)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: one call = one rising edge; chk pushes the expected post-edge outputs
    task automatic cyc(
        input logic r, input logic wr, input logic [3:0] wa, input logic [W-1:0] wd,
        input logic bwr, input logic [2:0] ba, input logic [W-1:0] bd,
        input logic [3:0] a1, input logic [3:0] a2, input logic [2:0] ab,
        input logic iv, input logic ib, input logic [3:0] ida,
        input logic chk, input logic [W-1:0] e1, input logic [W-1:0] e2,
        input logic [W-1:0] eb, input logic ehz);
        @(posedge clk);
        #1;
        rst = r; wb_wr_reg = wr; wb_rd_addr = wa; wb_rd_data = wd;
        wb_wr_breg = bwr; wb_bd_addr = ba; wb_bd_data = bd;
        rs1_addr = a1; rs2_addr = a2; bs_addr = ab;
        iss_valid = iv; iss_is_breg = ib; iss_dst_addr = ida;
        rd_req = chk;
        if (chk) exp_q.push_back({e1, e2, eb, ehz});
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    // monitor / scoreboard
    initial begin
        logic [3*W:0] e;
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL exp_q_underflow: got empty queue, expected an entry");
                end else begin
                    e = exp_q.pop_front();
                    check("rs1_data", rs1_data, e[3*W:2*W+1]);
                    check("rs2_data", rs2_data, e[2*W:W+1]);
                    check("bs_data",  bs_data,  e[W:1]);
                    check("hazard",   {{(W-1){1'b0}}, hazard}, {{(W-1){1'b0}}, e[0]});
                end
            end
        end
    end

    initial begin
        //  rst wr wa   wd            bwr ba  bd       a1 a2 ab  iv ib ida   chk e1          e2       eb       hz
        cyc(1, 1, 4'd3, 32'h55,       0, 3'd0, 32'h0,  0, 0, 0,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 1, 4'd5, 32'h1234,     0, 3'd0, 32'h0,  0, 0, 0,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  5, 0, 0,  0, 0, 4'd0, 1, 32'h1234,  32'h0,   32'h0,   0);
        cyc(0, 1, 4'd0, 32'hFFFF,     0, 3'd0, 32'h0,  5, 3, 0,  0, 0, 4'd0, 1, 32'h1234,  32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 0, 0,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 1, 4'd5, 32'h5678,     1, 3'd3, 32'hAB, 5, 0, 3,  0, 0, 4'd0, 1, 32'h5678,  32'h0,   32'hAB,  0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 7, 0,  1, 0, 4'd7, 0, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 7, 0,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'h0,   1);
        cyc(0, 1, 4'd7, 32'h77,       0, 3'd0, 32'h0,  0, 7, 0,  0, 0, 4'd0, 1, 32'h0,     32'h77,  32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 7, 0,  0, 0, 4'd0, 1, 32'h0,     32'h77,  32'h0,   0);
        cyc(0, 1, 4'd4, 32'h44,       0, 3'd0, 32'h0,  0, 0, 0,  1, 0, 4'd4, 0, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  4, 0, 0,  0, 0, 4'd0, 1, 32'h44,    32'h0,   32'h0,   1);
        cyc(0, 1, 4'd4, 32'h45,       0, 3'd0, 32'h0,  4, 0, 0,  0, 0, 4'd0, 1, 32'h45,    32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 0, 0,  1, 0, 4'd0, 0, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 0, 0,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 1, 4'd9, 32'h99,       1, 3'd2, 32'hB2, 0, 0, 0,  1, 0, 4'd9, 0, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  9, 0, 2,  1, 1, 4'hA, 1, 32'h99,    32'h0,   32'hB2,  1);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 0, 2,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'hB2,  1);
        cyc(1, 1, 4'd5, 32'hDEAD,     1, 3'd1, 32'hBEEF, 9, 5, 2, 1, 0, 4'd6, 1, 32'h0,    32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  9, 5, 2,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  6, 0, 1,  0, 0, 4'd0, 1, 32'h0,     32'h0,   32'h0,   0);
        cyc(0, 0, 4'd0, 32'h0,        0, 3'd0, 32'h0,  0, 0, 0,  0, 0, 4'd0, 0, 32'h0,     32'h0,   32'h0,   0);
        repeat (3) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
